// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall sequencer.
// Holds the FSM encoding, register-zero and NOP constants.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // True when an operand that is actually read matches rd.
  function automatic logic rs_hit(
    input logic       use_rs,
    input logic [4:0] rs,
    input logic [4:0] rd
  );
    return use_rs & (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count enabled cycles, clear wins, stop at max.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != CNT_MAX)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use stall, branch flush, memory
// freeze with timeout, and saturating stall/flush counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if2id_write_o,
  output logic             if2id_flush_o,
  output logic             id2ex_write_o,
  output logic             id2ex_bubble_o,
  output logic             ex2mem_write_o,
  output logic             mem2wb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              err_set;

  logic loaduse;
  logic memstall;
  logic freeze;
  logic lu_stall;
  logic br_flush;

  assign loaduse = ex_memread_i
                 & (ex_rd_i != REG_ZERO)
                 & (rs_hit(id_use_rs1_i, id_rs1_i, ex_rd_i)
                  | rs_hit(id_use_rs2_i, id_rs2_i, ex_rd_i));

  assign memstall = mem_req_i & ~mem_ack_i;

  // State, wait counter and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) begin
        mem_err_o <= 1'b1;
      end
    end
  end

  // Next state and hazard classification by priority.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    freeze    = 1'b0;
    lu_stall  = 1'b0;
    br_flush  = 1'b0;
    unique case (state)
      RUN: begin
        if (memstall) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else if (loaduse) begin
          lu_stall = 1'b1;
        end else if (branch_taken_i) begin
          br_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (memstall) begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_MAX) begin
            state_nxt = ERROR;
            err_set   = 1'b1;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
          if (loaduse) begin
            lu_stall = 1'b1;
          end else if (branch_taken_i) begin
            br_flush = 1'b1;
          end
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        freeze    = 1'b1;
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Map hazard class to pipeline register controls.
  always_comb begin
    pc_write_o      = 1'b1;
    if2id_write_o   = 1'b1;
    if2id_flush_o   = 1'b0;
    id2ex_write_o   = 1'b1;
    id2ex_bubble_o  = 1'b0;
    ex2mem_write_o  = 1'b1;
    mem2wb_bubble_o = 1'b0;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if2id_write_o  = 1'b0;
      id2ex_write_o  = 1'b0;
      ex2mem_write_o = 1'b0;
    end else if (freeze) begin
      pc_write_o      = 1'b0;
      if2id_write_o   = 1'b0;
      id2ex_write_o   = 1'b0;
      ex2mem_write_o  = 1'b0;
      mem2wb_bubble_o = 1'b1;
    end else if (lu_stall) begin
      pc_write_o     = 1'b0;
      if2id_write_o  = 1'b0;
      id2ex_bubble_o = 1'b1;
    end else if (br_flush) begin
      if2id_flush_o = 1'b1;
    end
  end

  logic stall_en;

  assign stall_en = ~pc_write_o & ~rst_i;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (stall_en),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (if2id_flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed cases
// plus randomized traffic against a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int T    = 4;
  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   rs1 = '0;
  logic [4:0]   rs2 = '0;
  logic         use1 = 1'b0;
  logic         use2 = 1'b0;
  logic         memrd = 1'b0;
  logic [4:0]   rd = '0;
  logic         br = 1'b0;
  logic         req = 1'b0;
  logic         ack = 1'b0;
  logic         pc_w, if_w, if_fl, ex_w, ex_bub, mem_w, wb_bub;
  logic [W-1:0] scnt, fcnt;
  logic         merr;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .id_rs1_i        (rs1),
    .id_rs2_i        (rs2),
    .id_use_rs1_i    (use1),
    .id_use_rs2_i    (use2),
    .ex_memread_i    (memrd),
    .ex_rd_i         (rd),
    .branch_taken_i  (br),
    .mem_req_i       (req),
    .mem_ack_i       (ack),
    .pc_write_o      (pc_w),
    .if2id_write_o   (if_w),
    .if2id_flush_o   (if_fl),
    .id2ex_write_o   (ex_w),
    .id2ex_bubble_o  (ex_bub),
    .ex2mem_write_o  (mem_w),
    .mem2wb_bubble_o (wb_bub),
    .stall_cnt_o     (scnt),
    .flush_cnt_o     (fcnt),
    .mem_err_o       (merr)
  );

  typedef struct {
    logic [6:0] ctrl;
    int         scnt;
    int         fcnt;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // model state
  logic       m_err = 1'b0;
  int         m_run = 0;
  int         m_scnt = 0;
  int         m_fcnt = 0;
  logic [6:0] last_ctrl = '0;

  // ctrl = {pc_w, if_w, if_fl, ex_w, ex_bub, mem_w, wb_bub}
  localparam logic [6:0] C_RST   = 7'b000_0000;
  localparam logic [6:0] C_FRZ   = 7'b000_0001;
  localparam logic [6:0] C_LU    = 7'b000_1110;
  localparam logic [6:0] C_BR    = 7'b111_1010;
  localparam logic [6:0] C_IDLE  = 7'b110_1010;

  task automatic drive(
    input logic       r,
    input logic [4:0] a1,
    input logic [4:0] a2,
    input logic       u1,
    input logic       u2,
    input logic       mr,
    input logic [4:0] d,
    input logic       b,
    input logic       rq,
    input logic       ak
  );
    exp_t e;
    logic stall;
    logic lu;
    @(posedge clk);
    // advance the model across the edge just taken
    if (rst) begin
      m_err  = 1'b0;
      m_run  = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      if (!m_err) begin
        if (req && !ack) begin
          if (m_run == T) m_err = 1'b1;
          else m_run = m_run + 1;
        end else begin
          m_run = 0;
        end
      end
      if (!last_ctrl[6] && m_scnt < MAXC) m_scnt = m_scnt + 1;
      if (last_ctrl[4] && m_fcnt < MAXC) m_fcnt = m_fcnt + 1;
    end
    #1;
    rst = r; rs1 = a1; rs2 = a2; use1 = u1; use2 = u2;
    memrd = mr; rd = d; br = b; req = rq; ack = ak;
    stall = rq & ~ak;
    lu = mr && (d != 0) && ((u1 && d == a1) || (u2 && d == a2));
    if (r) e.ctrl = C_RST;
    else if (m_err || stall) e.ctrl = C_FRZ;
    else if (lu) e.ctrl = C_LU;
    else if (b) e.ctrl = C_BR;
    else e.ctrl = C_IDLE;
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    e.err  = m_err;
    last_ctrl = e.ctrl;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: pop expected record and compare each cycle
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_w, if_w, if_fl, ex_w, ex_bub, mem_w, wb_bub};
        checks++;
        if (act !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl t=%0t got %b want %b", $time, act, e.ctrl);
        end
        checks++;
        if (scnt !== W'(e.scnt)) begin
          errors++;
          $display("FAIL stall_cnt t=%0t got %0d want %0d",
                   $time, scnt, e.scnt);
        end
        checks++;
        if (fcnt !== W'(e.fcnt)) begin
          errors++;
          $display("FAIL flush_cnt t=%0t got %0d want %0d",
                   $time, fcnt, e.fcnt);
        end
        checks++;
        if (merr !== e.err) begin
          errors++;
          $display("FAIL mem_err t=%0t got %b want %b", $time, merr, e.err);
        end
      end
    end
  end

  initial begin
    logic hold;
    logic r, rq, ak;
    int   ackp;
    // reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs1
    drive(0, 5, 0, 1, 0, 1, 5, 0, 0, 0);
    idle(2);
    // x0 never stalls; unused rs2 never stalls
    drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 7, 0, 0, 1, 7, 0, 0, 0);
    // branch alone, then branch with load-use
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    drive(0, 3, 0, 1, 0, 1, 3, 1, 0, 0);
    idle(1);
    // memory wait of three cycles, then ack
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    // timeout into ERROR, inputs ignored, then reset
    repeat (5) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 2, 0, 1, 0, 1, 2, 0, 1, 1);
    idle(2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // saturation of stall counter
    repeat (20) drive(0, 4, 4, 0, 1, 1, 4, 0, 0, 0);
    idle(2);
    // randomized traffic
    hold = 1'b0;
    ackp = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) ackp = $urandom_range(1, 9);
      r  = ($urandom_range(0, 149) == 0);
      rq = hold | ($urandom_range(0, 3) == 0);
      ak = rq & ($urandom_range(0, 9) < ackp);
      hold = rq & ~ak & ($urandom_range(0, 19) != 0);
      drive(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), rq, ak);
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central sequencer for the five-stage pipeline. It drives write-enable, bubble and flush controls to the PC, IF2ID, ID2EX, EX2MEM and MEM2WB registers.
- It detects load-use hazards and branch-taken flushes, and freezes the pipeline while a data-memory access is outstanding.
- It keeps saturating performance counters and raises a sticky error on a memory timeout.
- Sits beside the datapath, at the same hierarchy level as the pipeline registers.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles of mem_req_i without mem_ack_i before error.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- id_rs1_i  in  5  RS1 field of the instruction in ID
- id_rs2_i  in  5  RS2 field of the instruction in ID
- id_use_rs1_i  in  1  ID instruction reads RS1
- id_use_rs2_i  in  1  ID instruction reads RS2
- ex_memread_i  in  1  MemRead of the instruction in EX
- ex_rd_i  in  5  RD of the instruction in EX
- branch_taken_i  in  1  branch resolved taken in ID
- mem_req_i  in  1  MEM stage has a load/store in flight
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- if2id_write_o  out  1  IF2ID load enable
- if2id_flush_o  out  1  IF2ID loads NOP (instruction 0)
- id2ex_write_o  out  1  ID2EX load enable
- id2ex_bubble_o  out  1  ID2EX loads all-zero controls
- ex2mem_write_o  out  1  EX2MEM load enable
- mem2wb_bubble_o  out  1  MEM2WB loads RegWrite=0
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0
- flush_cnt_o  out  CNT_W  cycles with if2id_flush_o=1
- mem_err_o  out  1  sticky memory timeout error

Behaviour:
- Reset is synchronous and active-high. Clock and reset ports are clk_i and rst_i.
- On a clk_i edge with rst_i=1: state<=RUN, wait_cnt<=0, both performance counters<=0, mem_err_o<=0.
- While rst_i=1, outputs are overridden: all *_write_o=0 and all bubble/flush=0.
- States: RUN, MEM_WAIT, ERROR. Outputs are combinational from state and inputs; all state is registered.
- Hazard terms:
  - loaduse = ex_memread_i & (ex_rd_i!=0) & ((id_use_rs1_i & ex_rd_i==id_rs1_i) | (id_use_rs2_i & ex_rd_i==id_rs2_i)).
  - memstall = mem_req_i & ~mem_ack_i.
- Priority: ERROR > memstall > loaduse > branch_taken_i.
- Defaults: all *_write_o=1 and all bubble/flush=0.
- RUN with memstall: all *_write_o=0 and mem2wb_bubble_o=1. Next state MEM_WAIT, wait_cnt<=1.
- RUN with loaduse, no memstall:
  - pc_write_o=0, if2id_write_o=0, id2ex_bubble_o=1.
  - Exactly a one-cycle stall, because the load then moves to MEM.
  - branch_taken_i is ignored, since the operand is not yet valid.
- RUN with branch_taken_i only: if2id_flush_o=1, writes stay enabled. Flush lasts exactly one cycle.
- MEM_WAIT:
  - Freeze outputs persist while mem_ack_i=0; wait_cnt increments.
  - If mem_ack_i=1: outputs as RUN for this cycle (loaduse and branch evaluated normally). Next state RUN, wait_cnt<=0.
  - If wait_cnt==MEM_TIMEOUT and mem_ack_i=0: next state ERROR, mem_err_o<=1.
  - mem_req_i dropping without ack is treated as ack.
- ERROR: full freeze (as in MEM_WAIT), ignoring all inputs, until rst_i.
- Counters:
  - stall_cnt_o increments on each cycle with pc_write_o=0 and rst_i=0.
  - flush_cnt_o increments on each cycle with if2id_flush_o=1.
  - Both saturate at 2^CNT_W-1; no wrap.
- ex_rd_i=0 never causes a stall.
- Reset asserted mid-MEM_WAIT returns the block to RUN on the next edge.

Decomposition:
- Shared pipeline package holds:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - REG_ZERO=5'd0;
  - NOP instruction constant 32'h0000_0000.
- One natural sub-module, sat_counter (CNT_W, synchronous active-high clear, enable), instanced twice.

Test Plan:
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs1_i=5, id_use_rs1_i=1 for one cycle -> pc_write_o=0, if2id_write_o=0, id2ex_bubble_o=1 that cycle only; stall_cnt_o=1.
- x0 and no-use checks:
  - ex_rd_i=0 with id_rs1_i=0 -> no stall.
  - ex_rd_i=7, id_rs2_i=7, id_use_rs2_i=0 -> no stall.
- Branch: branch_taken_i=1 alone -> if2id_flush_o=1 one cycle, flush_cnt_o=1. The same cycle combined with loaduse -> no flush, stall only.
- Memory wait: mem_req_i=1, mem_ack_i=0 for 3 cycles, then ack -> freeze outputs for 3 cycles, RUN outputs on the ack cycle; stall_cnt_o=3.
- Timeout: MEM_TIMEOUT=4, mem_req_i=1 and no ack -> mem_err_o=1 after the 5th wait cycle; freeze persists until rst_i=1 for one edge; then counters=0, mem_err_o=0.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> stall_cnt_o holds 15.
